// File: rtl/adder_seq16_ctrl.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice is reused for every
// nibble of the operands, producing a W-bit result after NIBBLES cycles.
`timescale 1ns/1ps

module adder_seq16_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_c3,
  output logic       o_cout
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is expanded from generate/propagate terms.
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_c3   = w_c[3];
  assign o_cout = w_c[4];
endmodule

// Handshake: start is taken on a rising edge only while ready=1; done is a
// one-cycle pulse in the first IDLE cycle after the final nibble, during
// which ready is already high so a new start can be taken back-to-back.
module adder_seq16_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   abort,
  output logic                   ready,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   o_dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_index;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_done;

  logic          w_accept;
  logic          w_step;
  logic          w_finish;
  logic          w_last;
  logic [3:0]    w_nib_a;
  logic [3:0]    w_nib_b;
  logic [3:0]    w_slice_sum;
  logic          w_slice_c3;
  logic          w_slice_cout;

  assign w_last = (r_index == LAST_IDX);

  // Index is decoded against legal nibble numbers only, so no out-of-range
  // slice of the operands can ever be addressed.
  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_index == IW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  adder_seq16_cla4 u_slice (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_c    (r_carry),
    .o_sum  (w_slice_sum),
    .o_c3   (w_slice_c3),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_index <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_index <= '0;
      end else if (w_step) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (r_index == IW'(i)) begin
            r_sum[4*i +: 4] <= w_slice_sum;
          end
        end
        r_carry <= w_slice_cout;
        if (w_finish) begin
          r_index <= '0;
          r_cout  <= w_slice_cout;
          r_ovf   <= w_slice_c3 ^ w_slice_cout;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end else if (r_state == S_RUN) begin
        // Aborted: drop the operation, keep cout/ovf from the last result.
        r_index <= '0;
      end
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign done        = r_done;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_adder_seq16_ctrl.sv
// Bench for adder_seq16_ctrl: directed vector table and corner sequences on a
// 4-nibble instance, then random back-to-back traffic on 4- and 2-nibble copies.
`timescale 1ns/1ps

module tb_adder_seq16_ctrl;
  localparam int NOPS = 10000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start4 = 0, cin4 = 0, abort4 = 0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        ready4, done4, cout4, ovf4, dbg4;
  logic [15:0] sum4;

  logic        start2 = 0, cin2 = 0, abort2 = 0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        ready2, done2, cout2, ovf2, dbg2;
  logic [7:0]  sum2;

  adder_seq16_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .abort(abort4), .ready(ready4), .done(done4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .o_dbg_state(dbg4)
  );

  adder_seq16_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .abort(abort2), .ready(ready2), .done(done2), .sum(sum2), .cout(cout2),
    .ovf(ovf2), .o_dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Signed overflow from operand/result signs (reference, not carry-based).
  function automatic logic ref_ovf(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] s);
    return (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  logic [16:0] exp_q4[$];
  logic        exp_ovf_q4[$];
  int          exp_cyc_q4[$];
  logic [8:0]  exp_q2[$];
  logic        exp_ovf_q2[$];
  int          exp_cyc_q2[$];

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_done4(output int lat);
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op4(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                     output int lat, output logic rdy0);
    a4 = xa; b4 = xb; cin4 = xc; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    rdy0 = ready4;
    wait_done4(lat);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   lat;
    logic rdy0;
    int   ndone;
    int   first_lat;
    logic [15:0] sum_seen;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Reset values while rst_n is held low.
    #12;
    check("reset_flags", {28'b0, ready4, done4, cout4, ovf4}, 32'h8);
    check("reset_sum", {16'b0, sum4}, 32'h0);

    // First start on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    op4(16'h0001, 16'h0002, 1'b0, lat, rdy0);
    check("first_start_accepted", {31'b0, rdy0}, 32'h0);
    check("first_latency", 32'(lat), 32'd4);
    check("first_sum", {15'b0, ovf4, cout4, sum4}, 32'h3);

    // Vector table.
    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, lat, rdy0);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_result", i), {15'b0, ovf4, cout4, sum4},
            {15'b0, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
    end

    // done is a single pulse and the result holds in IDLE.
    @(negedge clk);
    check("done_single_pulse", {31'b0, done4}, 32'h0);
    check("result_holds", {14'b0, ready4, ovf4, cout4, sum4}, {14'b0, 1'b1, 1'b1, 1'b0, 16'h8000});

    // Back-to-back: start held high, new operands presented in the done cycle.
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done4(lat);
    check("b2b_first_latency", 32'(lat), 32'd4);
    check("b2b_first_result", {15'b0, ovf4, cout4, sum4}, 32'h3333);
    a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    wait_done4(lat);
    check("b2b_second_latency", 32'(lat), 32'd4);
    check("b2b_second_result", {15'b0, ovf4, cout4, sum4}, {15'b0, 1'b0, 1'b1, 16'hFFFF});

    // start during RUN is ignored.
    a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0; first_lat = -1; sum_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = k;
          sum_seen  = sum4;
        end
      end
      if (k == 1) begin
        start4 = 1'b1; a4 = 16'h0000; b4 = 16'h0000;
      end else begin
        start4 = 1'b0;
      end
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);
    check("ignored_start_latency", 32'(first_lat), 32'd4);
    check("ignored_start_sum", {16'b0, sum_seen}, 32'h0100);

    // Abort in the second RUN cycle keeps cout/ovf and never signals done.
    op4(16'h8000, 16'h8000, 1'b0, lat, rdy0);
    check("pre_abort_result", {15'b0, ovf4, cout4, sum4}, {15'b0, 1'b1, 1'b1, 16'h0000});
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    abort4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_flags", {28'b0, ready4, done4, cout4, ovf4}, 32'hB);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // start and abort together in IDLE: start wins.
    a4 = 16'hF0F0; b4 = 16'h1F1F; cin4 = 1'b0; start4 = 1'b1; abort4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    check("start_wins_accepted", {31'b0, ready4}, 32'h0);
    wait_done4(lat);
    check("start_wins_latency", 32'(lat), 32'd4);
    check("start_wins_result", {15'b0, ovf4, cout4, sum4}, {15'b0, 1'b0, 1'b1, 16'h100F});

    // Reset mid-RUN: outputs clear at once, no done after release.
    a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {28'b0, ready4, done4, cout4, ovf4}, 32'h8);
    check("midrun_reset_sum", {16'b0, sum4}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    check("reset_no_done", 32'(ndone), 32'd0);
    check("reset_ready", {31'b0, ready4}, 32'h1);

    // Random back-to-back traffic on both widths in parallel.
    fork
      begin : rnd4
        int issued;
        int got;
        int guard;
        logic [16:0] e;
        logic        eo;
        int          ec;
        issued = 0; got = 0; guard = 0;
        while (got < NOPS && guard < 60000) begin
          @(negedge clk);
          guard++;
          if (done4 === 1'b1) begin
            if (exp_q4.size() == 0) begin
              check("rnd4_spurious_done", 32'h1, 32'h0);
            end else begin
              e = exp_q4.pop_front(); eo = exp_ovf_q4.pop_front(); ec = exp_cyc_q4.pop_front();
              check("rnd4_result", {14'b0, eo, cout4, sum4}, {14'b0, eo == eo ? ovf4 : 1'b0, e} ^
                    {14'b0, ovf4 ^ eo, 17'b0});
              check("rnd4_latency", 32'(cyc), 32'(ec));
              got++;
            end
          end
          if (ready4 === 1'b1 && issued < NOPS) begin
            a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom_range(0, 1));
            start4 = 1'b1;
            exp_q4.push_back({1'b0, a4} + {1'b0, b4} + 17'(cin4));
            exp_ovf_q4.push_back(ref_ovf(16, 32'(a4), 32'(b4), 32'(16'(a4 + b4 + 16'(cin4)))));
            exp_cyc_q4.push_back(cyc + 1 + 4);
            issued++;
          end else begin
            start4 = (issued < NOPS) ? 1'($urandom_range(0, 1)) : 1'b0;
            a4 = 16'($urandom); b4 = 16'($urandom);
          end
        end
        start4 = 1'b0;
        if (got < NOPS) check("rnd4_timeout", 32'(got), 32'(NOPS));
      end
      begin : rnd2
        int issued;
        int got;
        int guard;
        logic [8:0] e;
        logic       eo;
        int         ec;
        issued = 0; got = 0; guard = 0;
        while (got < NOPS && guard < 60000) begin
          @(negedge clk);
          guard++;
          if (done2 === 1'b1) begin
            if (exp_q2.size() == 0) begin
              check("rnd2_spurious_done", 32'h1, 32'h0);
            end else begin
              e = exp_q2.pop_front(); eo = exp_ovf_q2.pop_front(); ec = exp_cyc_q2.pop_front();
              check("rnd2_result", {22'b0, ovf2, cout2, sum2}, {22'b0, eo, e});
              check("rnd2_latency", 32'(cyc), 32'(ec));
              got++;
            end
          end
          if (ready2 === 1'b1 && issued < NOPS) begin
            a2 = 8'($urandom); b2 = 8'($urandom); cin2 = 1'($urandom_range(0, 1));
            start2 = 1'b1;
            exp_q2.push_back({1'b0, a2} + {1'b0, b2} + 9'(cin2));
            exp_ovf_q2.push_back(ref_ovf(8, 32'(a2), 32'(b2), 32'(8'(a2 + b2 + 8'(cin2)))));
            exp_cyc_q2.push_back(cyc + 1 + 2);
            issued++;
          end else begin
            start2 = (issued < NOPS) ? 1'($urandom_range(0, 1)) : 1'b0;
            a2 = 8'($urandom); b2 = 8'($urandom);
          end
        end
        start2 = 1'b0;
        if (got < NOPS) check("rnd2_timeout", 32'(got), 32'(NOPS));
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
